// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: machine states, opcodes
// and the one-hot instruction flag vector.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_PREP    = 2'b01,
        ST_EXEC    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_JG   = 4'h2;
    localparam logic [3:0] OP_IN1  = 4'h3;
    localparam logic [3:0] OP_OUT1 = 4'h4;
    localparam logic [3:0] OP_MOVI = 4'h5;
    localparam logic [3:0] OP_HALT = 4'h6;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_MOVA = 4'hA;
    localparam logic [3:0] OP_MOVB = 4'hB;
    localparam logic [3:0] OP_MOVC = 4'hC;
    localparam logic [3:0] OP_MOVD = 4'hD;

    // mova is bit 0, halt is bit 11
    typedef struct packed {
        logic halt;
        logic movi;
        logic out1;
        logic in1;
        logic jg;
        logic jmp;
        logic sub;
        logic add;
        logic movd;
        logic movc;
        logic movb;
        logic mova;
    } flags_t;

    localparam flags_t FLAGS_NONE = '0;

endpackage

// File: rtl/instr_sequencer_decode.sv
// Combinational opcode decoder: ir[7:4] to a one-hot flag vector.
// Unmapped opcodes decode to no flags (NOP).
module instr_decode
    import instr_sequencer_pkg::*;
(
    input  logic [3:0] i_opcode,
    output flags_t     o_flags
);

    always_comb begin
        o_flags = FLAGS_NONE;
        case (i_opcode)
            OP_JMP:  o_flags.jmp  = 1'b1;
            OP_JG:   o_flags.jg   = 1'b1;
            OP_IN1:  o_flags.in1  = 1'b1;
            OP_OUT1: o_flags.out1 = 1'b1;
            OP_MOVI: o_flags.movi = 1'b1;
            OP_HALT: o_flags.halt = 1'b1;
            OP_ADD:  o_flags.add  = 1'b1;
            OP_SUB:  o_flags.sub  = 1'b1;
            OP_MOVA: o_flags.mova = 1'b1;
            OP_MOVB: o_flags.movb = 1'b1;
            OP_MOVC: o_flags.movc = 1'b1;
            OP_MOVD: o_flags.movd = 1'b1;
            default: o_flags = FLAGS_NONE;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Three-phase FETCH/PREP/EXEC sequencer with registered one-hot instruction
// flags, a greater flag and a completed-instruction counter.
module instr_sequencer
    import instr_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sm_en,
    input  logic       decoder_en,
    input  logic [7:0] ir,
    input  logic       g_en,
    input  logic       alu_gt,
    output logic [1:0] sm,
    output logic       mova,
    output logic       movb,
    output logic       movc,
    output logic       movd,
    output logic       add,
    output logic       sub,
    output logic       jmp,
    output logic       jg,
    output logic       in1,
    output logic       out1,
    output logic       movi,
    output logic       halt,
    output logic       gf,
    output logic [7:0] instr_cnt
);

    state_t     r_sm;
    flags_t     r_flags;
    logic [7:0] r_cnt;
    logic       r_gf;

    state_t     w_sm_nxt;
    flags_t     w_flags_nxt;
    logic [7:0] w_cnt_nxt;
    flags_t     w_dec;
    // next-state kept on a plain net so the state register input is observable
    wire  [1:0] w_sm_d;

    assign w_sm_d = w_sm_nxt;

    instr_decode u_decode (
        .i_opcode (ir[7:4]),
        .o_flags  (w_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sm    <= ST_FETCH;
            r_flags <= FLAGS_NONE;
            r_cnt   <= 8'h00;
            r_gf    <= 1'b0;
        end else begin
            r_sm    <= state_t'(w_sm_d);
            r_flags <= w_flags_nxt;
            r_cnt   <= w_cnt_nxt;
            if (g_en)
                r_gf <= alu_gt;
        end
    end

    // A halted instruction simply sits in EXEC while sm_en stays low.
    always_comb begin
        w_sm_nxt    = r_sm;
        w_flags_nxt = r_flags;
        w_cnt_nxt   = r_cnt;
        if (r_sm == ST_ILLEGAL) begin
            w_sm_nxt    = ST_FETCH;
            w_flags_nxt = FLAGS_NONE;
        end else if (sm_en) begin
            case (r_sm)
                ST_FETCH: w_sm_nxt = ST_PREP;
                ST_PREP: begin
                    w_sm_nxt    = ST_EXEC;
                    w_flags_nxt = decoder_en ? w_dec : FLAGS_NONE;
                end
                ST_EXEC: begin
                    w_sm_nxt    = ST_FETCH;
                    w_flags_nxt = FLAGS_NONE;
                    w_cnt_nxt   = r_cnt + 8'h01;
                end
                default: w_sm_nxt = ST_FETCH;
            endcase
        end
    end

    assign sm        = r_sm;
    assign mova      = r_flags.mova;
    assign movb      = r_flags.movb;
    assign movc      = r_flags.movc;
    assign movd      = r_flags.movd;
    assign add       = r_flags.add;
    assign sub       = r_flags.sub;
    assign jmp       = r_flags.jmp;
    assign jg        = r_flags.jg;
    assign in1       = r_flags.in1;
    assign out1      = r_flags.out1;
    assign movi      = r_flags.movi;
    assign halt      = r_flags.halt;
    assign gf        = r_gf;
    assign instr_cnt = r_cnt;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk, rst_n.
REQ-002 Parameter: none; all encodings SHALL come from the shared package.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 sm_en  input  1  advance enable from the controller; 0 freezes the state and the flags.
REQ-006 decoder_en  input  1  decode gate from the controller; sampled at the PREP->EXEC edge.
REQ-007 ir  input  8  instruction register; ir[7:4] is the opcode, stable during PREP and EXEC.
REQ-008 g_en  input  1  greater-flag load strobe.
REQ-009 alu_gt  input  1  ALU "greater" result, captured into gf on g_en.
REQ-010 sm  output  2  machine state: 00 FETCH, 01 PREP, 10 EXEC.
REQ-011 mova, movb, movc, movd, add, sub, jmp, jg, in1, out1, movi, halt  output  1 each  registered one-hot instruction flags.
REQ-012 gf  output  1  registered greater flag.
REQ-013 instr_cnt  output  8  count of completed instructions.

Function
REQ-014 State transitions with sm_en=1: FETCH->PREP->EXEC->FETCH, one clock per state.
REQ-015 With sm_en=0, sm, the flags and instr_cnt SHALL hold their values.
REQ-016 Encoding 11 is illegal; from 11, sm SHALL go to FETCH on the next edge regardless of sm_en, with flags cleared.
REQ-017 Opcode map (ir[7:4]):
- 0001 jmp; 0010 jg; 0011 in1; 0100 out1; 0101 movi; 0110 halt.
- 1000 add; 1001 sub; 1010 mova; 1011 movb; 1100 movc; 1101 movd.
- 0000, 0111 and 1110-1111 are NOP: all flags 0.
REQ-018 On the PREP->EXEC edge, the flags SHALL load the decode of ir when decoder_en=1, and all-zero when decoder_en=0.
REQ-019 On the EXEC->FETCH edge, all flags SHALL clear to 0, so flags are non-zero only while sm=EXEC.
REQ-020 At most one flag SHALL be 1 in any cycle.
REQ-021 Halt: while sm=EXEC with halt=1 and sm_en=0, sm SHALL stay in EXEC and halt SHALL stay 1 until reset.
REQ-022 instr_cnt SHALL increment on each EXEC->FETCH edge, wrapping 8'hFF->8'h00.
REQ-023 gf SHALL load alu_gt on any edge with g_en=1, in any state, and otherwise hold.
REQ-024 The block SHALL add no extra latency: flag-to-output and state-to-output paths are registers only.

Reset
REQ-025 When rst_n=0 at an edge: sm=00, all flags=0, gf=0, instr_cnt=0.
REQ-026 Reset SHALL take priority over sm_en, g_en and the halt hold.
REQ-027 Reset asserted mid-instruction (PREP or EXEC) SHALL abort the instruction without incrementing instr_cnt.

Structure
REQ-028 The shared package SHALL hold:
- the state encodings FETCH/PREP/EXEC;
- the 4-bit opcode constants;
- the typedef for the 12-bit flag vector.
REQ-029 A purely combinational sub-module, instr_decode (ir[7:4] -> 12-bit one-hot), SHALL be instantiated once; registers stay in instr_sequencer.

Verification
REQ-030 The bench SHALL cover the following scenarios:
- Reset, then sm_en=1 held, ir=8'h8x: sm sequence 00,01,10,00; add=1 only in the EXEC cycle; instr_cnt=1 after the fourth edge.
- ir=8'h6x (halt), sm_en driven 0 once sm=10: sm holds 10 and halt holds 1 for 20 cycles; rst_n=0 for one edge gives sm=00, halt=0.
- Sweep all 16 opcodes: exactly the mapped flag in EXEC; opcodes 0,7,E,F give all flags 0; instr_cnt advances each instruction.
- decoder_en=0 at the PREP->EXEC edge with ir=8'h9x: sub=0 throughout EXEC.
- g_en=1, alu_gt=1 at an edge gives gf=1; g_en=0, alu_gt=0 leaves gf=1; then g_en=1, alu_gt=0 gives gf=0.
- 256 NOP instructions from reset: instr_cnt returns to 8'h00; force sm=11 and sm returns to 00 in one edge.
